bram_addr_sequencer: RTL and testbench

Parametrised BRAM read-address sequencer. It sits between the DES datapath controller and a simple-dual-port BRAM. It walks a programmable address window `[base_addr, last_addr]` with a programmable stride, and drives the BRAM enable. It also produces a `valid` that is aligned to the BRAM read latency. It adds start/restart, stall, and drain-aware completion.

---
 rtl/bram_seq_pkg.sv | 14 +
 rtl/bram_valid_pipe.sv | 30 +++
 rtl/bram_addr_sequencer.sv | 144 ++++++++++++++
 tb/tb_bram_addr_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_seq_pkg.sv
// Shared definitions for the BRAM read-address sequencer.
// Holds the sequencer state encoding and the supported read-latency ceiling.
package bram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int BRAM_SEQ_MAX_LAT = 4;

endpackage

// File: rtl/bram_valid_pipe.sv
// DEPTH-deep single-bit delay line with asynchronous active-low clear.
// Used both to align valid with BRAM read data and to time the drain phase.
module bram_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) sr <= '0;
        else        sr <= d;
      end
    end else begin : g_multi
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) sr <= '0;
        else        sr <= {sr[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/bram_addr_sequencer.sv
// BRAM read-address sequencer: walks [base_addr, last_addr] by stride, drives bram_en
// and a latency-aligned valid. Optional wrap-around mode is enabled by BRAM_SEQ_LOOP_EN.
module bram_addr_sequencer
  import bram_seq_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [ADDR_W-1:0] stride,
`ifdef BRAM_SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [ADDR_W-1:0] address,
  output logic              bram_en,
  output logic              valid,
  output logic              busy,
  output logic              finish,
  output logic              done_pulse
);

  localparam int LAT = (RD_LATENCY < 1) ? 1 :
                       ((RD_LATENCY > BRAM_SEQ_MAX_LAT) ? BRAM_SEQ_MAX_LAT : RD_LATENCY);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W:0]   addr_sum;
  logic              start_ok;
  logic              final_issue;
  logic              wrap;
  logic              enter_done;
  logic              drain_tap;
  logic              loop_req;

`ifdef BRAM_SEQ_LOOP_EN
  logic [ADDR_W-1:0] base_q;
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  // One extra bit so a step past the top of the address space cannot wrap below last_q.
  assign addr_sum = {1'b0, address} + {1'b0, stride_q};
  assign busy     = (state == RUN) || (state == DRAIN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bram_en     = 1'b0;
    start_ok    = 1'b0;
    final_issue = 1'b0;
    wrap        = 1'b0;
    enter_done  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          bram_en = 1'b1;
          if ((addr_sum > {1'b0, last_q}) || (address == last_q)) begin
            if (loop_req) begin
              wrap = 1'b1;
            end else begin
              final_issue = 1'b1;
              state_nxt   = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (drain_tap) begin
          enter_done = 1'b1;
          state_nxt  = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window registers, address counter and completion flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q     <= '0;
      stride_q   <= '0;
      address    <= '0;
      finish     <= 1'b0;
      done_pulse <= 1'b0;
`ifdef BRAM_SEQ_LOOP_EN
      base_q     <= '0;
`endif
    end else begin
      done_pulse <= enter_done | wrap;
      if (start_ok) begin
        last_q   <= last_addr;
        stride_q <= (stride == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1} : stride;
        address  <= base_addr;
        finish   <= 1'b0;
`ifdef BRAM_SEQ_LOOP_EN
        base_q   <= base_addr;
`endif
      end else begin
        if (bram_en && !final_issue) begin
`ifdef BRAM_SEQ_LOOP_EN
          if (wrap) address <= base_q;
          else      address <= addr_sum[ADDR_W-1:0];
`else
          address <= addr_sum[ADDR_W-1:0];
`endif
        end
        if (enter_done) finish <= 1'b1;
      end
    end
  end

  bram_valid_pipe #(.DEPTH(LAT)) u_valid_pipe (
    .clock (clock),
    .reset (reset),
    .d     (bram_en),
    .q     (valid)
  );

  // The final issue travels the same depth, so DRAIN ends exactly as the last word lands.
  bram_valid_pipe #(.DEPTH(LAT)) u_drain_pipe (
    .clock (clock),
    .reset (reset),
    .d     (final_issue),
    .q     (drain_tap)
  );

endmodule

// File: tb/tb_bram_addr_sequencer.sv
// Scoreboard bench for bram_addr_sequencer (ADDR_W=10, RD_LATENCY=3): stimulus pushes the
// expected address list of each pass; a negedge monitor pops and checks all outputs.
module tb_bram_addr_sequencer;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [AW-1:0] address;
  logic          bram_en, valid, busy, finish, done_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int exp_addr[$];
  int vq[$];
  int exp_done_cyc = -1;
  bit model_finish = 1'b0;

  bram_addr_sequencer #(.ADDR_W(AW), .RD_LATENCY(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .base_addr  (base_addr),
    .last_addr  (last_addr),
    .stride     (stride),
`ifdef BRAM_SEQ_LOOP_EN
    .loop       (1'b0),
`endif
    .address    (address),
    .bram_en    (bram_en),
    .valid      (valid),
    .busy       (busy),
    .finish     (finish),
    .done_pulse (done_pulse)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every output against the reference model each cycle.
  always @(negedge clock) begin
    logic exp_en, exp_valid, exp_busy, exp_done;
    if (reset) begin
      exp_done = (cyc == exp_done_cyc);
      if (exp_done) model_finish = 1'b1;
      exp_busy  = (exp_addr.size() > 0) || (cyc < exp_done_cyc);
      exp_en    = (exp_addr.size() > 0) && !stall;
      exp_valid = (vq.size() > 0) && (vq[0] == cyc);
      checkOutput("bram_en", int'(bram_en), int'(exp_en));
      checkOutput("valid", int'(valid), int'(exp_valid));
      checkOutput("busy", int'(busy), int'(exp_busy));
      checkOutput("done_pulse", int'(done_pulse), int'(exp_done));
      checkOutput("finish", int'(finish), int'(model_finish));
      if (exp_addr.size() > 0) checkOutput("address", int'(address), exp_addr[0]);
      if (exp_valid) void'(vq.pop_front());
      if (exp_en) begin
        void'(exp_addr.pop_front());
        vq.push_back(cyc + LAT);
        if (exp_addr.size() == 0) exp_done_cyc = cyc + LAT + 1;
      end
    end
  end

  task automatic clearModel();
    exp_addr.delete();
    vq.delete();
    exp_done_cyc = -1;
    model_finish = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(exp_addr.size() == 0 && cyc >= exp_done_cyc)) begin
      @(posedge clock); #1;
      n++;
      if (n > 5000) begin
        checkOutput("idle_timeout", 1, 0);
        clearModel();
      end
    end
  endtask

  task automatic startPass(input int b, input int l, input int s);
    int es, nreads;
    base_addr = AW'(b);
    last_addr = AW'(l);
    stride    = AW'(s);
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    es     = (s == 0) ? 1 : s;
    nreads = (b > l) ? 1 : ((l - b) / es + 1);
    for (int i = 0; i < nreads; i++) exp_addr.push_back(b + i * es);
    model_finish = 1'b0;
  endtask

  task automatic applyStimulus(input int b, input int l, input int s, input int stall_pct,
                               input int stall_from, input bit junk_start);
    int n = 0;
    waitIdle();
    startPass(b, l, s);
    while (exp_addr.size() > 0 && n < 5000) begin
      if (stall_from >= 0 && n >= stall_from && n < stall_from + 5) stall = 1'b1;
      else stall = ($urandom_range(99) < stall_pct);
      if (junk_start && n == 3) begin
        start     = 1'b1;
        base_addr = AW'($urandom);
        last_addr = AW'($urandom);
        stride    = AW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    if (n >= 5000) begin
      checkOutput("pass_timeout", 1, 0);
      clearModel();
    end
    // Random stall during drain must have no effect.
    repeat (LAT) begin
      stall = ($urandom_range(99) < stall_pct);
      @(posedge clock); #1;
    end
    stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_address", int'(address), 0);
    checkOutput("rst_bram_en", int'(bram_en), 0);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_finish", int'(finish), 0);
    checkOutput("rst_done_pulse", int'(done_pulse), 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    applyStimulus(4, 20, 5, 0, -1, 1'b0);
    applyStimulus(30, 10, 7, 0, -1, 1'b0);
    applyStimulus(0, 3, 0, 0, -1, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    applyStimulus(100, 200, 3, 0, 10, 1'b0);
    applyStimulus(0, 1023, 1, 0, -1, 1'b0);
    applyStimulus(50, 90, 4, 20, -1, 1'b1);
    applyStimulus(1020, 1023, 2, 0, -1, 1'b0);
    applyStimulus(7, 7, 9, 0, -1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      applyStimulus($urandom_range(1023), $urandom_range(1023), $urandom_range(31),
                    25, -1, (k % 4 == 0));
      if (k % 5 == 0) begin
        repeat ($urandom_range(4)) @(posedge clock);
        #1;
      end
    end

    // Asynchronous reset mid-pass with reads in flight.
    waitIdle();
    startPass(0, 600, 1);
    repeat (20) begin
      @(posedge clock); #1;
    end
    #2;
    reset = 1'b0;
    clearModel();
    #1;
    checkOutput("arst_address", int'(address), 0);
    checkOutput("arst_bram_en", int'(bram_en), 0);
    checkOutput("arst_valid", int'(valid), 0);
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_finish", int'(finish), 0);
    checkOutput("arst_done_pulse", int'(done_pulse), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    applyStimulus(10, 40, 6, 10, -1, 1'b0);
    waitIdle();
    repeat (3) @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
